// File: rtl/seg_display_monitor_pkg.sv
// Shared definitions for the HEX display monitor: glyph constants and FSM encoding.
// The glyph table is also used by the forward segment decoder for consistency checks.
package seg_display_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Active-low patterns, bit order g..a (bit6=g, bit0=a).
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_display_monitor_seg_to_nibble.sv
// Combinational reverse lookup: one 7-segment pattern back to a hex nibble.
// legal is low for any pattern that is not one of the 16 hex glyphs.
module seg_to_nibble
  import seg_display_monitor_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  logic [6:0] norm;

  assign norm = SEG_ACTIVE_LOW ? pattern : ~pattern;

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (norm == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_monitor.sv
// Decodes a HEX1/HEX0 segment pair back to a byte and checks that successive
// samples follow the counter sequence (+1, wrap, hold, or clear to zero).
module seg_display_monitor
  import seg_display_monitor_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit ALLOW_HOLD     = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  input  logic       check_en,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       illegal,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic       tracking
);

  state_t     state, next_state;
  logic [3:0] nib_hi, nib_lo;
  logic       legal_hi, legal_lo;
  logic [7:0] sampled;
  logic       legal_sample, illegal_now, mismatch_now, seq_ok;

  seg_to_nibble #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hi (
    .pattern (seg_hi),
    .nibble  (nib_hi),
    .legal   (legal_hi)
  );

  seg_to_nibble #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lo (
    .pattern (seg_lo),
    .nibble  (nib_lo),
    .legal   (legal_lo)
  );

  assign sampled = {nib_hi, nib_lo};

  // Illegal takes precedence: mismatch is only evaluated on fully legal samples.
  always_comb begin
    legal_sample = sample & legal_hi & legal_lo;
    illegal_now  = sample & ~(legal_hi & legal_lo);
    seq_ok       = (sampled == value + 8'd1) ||
                   (ALLOW_HOLD && (sampled == value)) ||
                   (sampled == '0);
    mismatch_now = legal_sample && (state == TRACK) && check_en && !seq_ok;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (legal_sample) next_state = TRACK;
  end

  always_comb begin
    tracking = (state == TRACK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value       <= '0;
      value_valid <= 1'b0;
      illegal     <= 1'b0;
      mismatch    <= 1'b0;
      err_count   <= '0;
    end else begin
      illegal  <= illegal_now;
      mismatch <= mismatch_now;
      if (legal_sample) begin
        value       <= sampled;
        value_valid <= 1'b1;
      end
      if ((illegal_now || mismatch_now) && (err_count != '1))
        err_count <= err_count + 8'd1;
    end
  end

endmodule
